dmem_top: RTL
=============

DMEM_TOP -- requirements
Module: dmem_top

Interface
REQ-001 Parameter: BUS_WIDTH, 16, data and address width; only 16 is supported.
REQ-002 Parameter: RAM_AW, 8, RAM address bits; the RAM holds 2^RAM_AW words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 MW  input  1  memory write enable from the control unit.
REQ-006 dp_address_out  input  BUS_WIDTH  datapath address (bus A).
REQ-007 dp_data_out  input  BUS_WIDTH  datapath write data (bus B).
REQ-008 gpio_in  input  BUS_WIDTH  external asynchronous input pins.
REQ-009 mem_data_in  output  BUS_WIDTH  read data returned to the datapath MD mux.
REQ-010 gpio_out  output  BUS_WIDTH  registered output port.
REQ-011 timer_irq  output  1  timer wrap interrupt, level.
REQ-012 bus_err  output  1  sticky flag: an access was made to an unmapped address.

Function
REQ-013 Address map:
- 0x0000..(2^RAM_AW-1): RAM.
- 0xFFF0: GPIO_OUT, read/write.
- 0xFFF1: GPIO_IN, read-only.
- 0xFFF2: TIMER_CNT, read/write.
- 0xFFF3: TIMER_CTRL, read/write. bit0 = enable, bit1 = wrap flag (write 1 to clear), bit2 = irq enable.
- All other addresses are unmapped.
REQ-014 Reads are combinational: mem_data_in reflects dp_address_out in the same cycle, with zero latency, so single-cycle execution works.
REQ-015 A write occurs on the rising edge when MW=1, with data dp_data_out. Read-during-write returns the old value; the new value is visible from the next cycle.
REQ-016 Unmapped reads return 0x0000; unmapped writes are ignored.
REQ-017 bus_err is set on the edge of any unmapped access while MW=1, and on any unmapped read address held at an edge. It stays set until reset.
REQ-018 GPIO_IN is passed through a two-flop synchronizer. A read returns the synchronized value, which lags a pin change by 2 cycles.
REQ-019 While enable=1, TIMER_CNT increments by 1 each cycle. It wraps 0xFFFF -> 0x0000, and the wrap sets the wrap flag.
REQ-020 A write to TIMER_CNT takes priority over the increment in the same cycle; the written value is loaded and no wrap is flagged that cycle.
REQ-021 If a wrap and a write-1-to-clear of the wrap flag occur in the same cycle, the set wins.
REQ-022 Writes to TIMER_CTRL bits 15:3 are ignored; those bits read as 0.
REQ-023 timer_irq = wrap flag AND irq enable. It is purely combinational from registered state.
REQ-024 Writes to GPIO_IN are ignored and do not set bus_err.

Reset
REQ-025 When reset is asserted, immediately and independently of clk:
- gpio_out, TIMER_CNT and TIMER_CTRL are cleared to 0.
- bus_err is cleared to 0.
- The synchronizer flops are cleared to 0.
- timer_irq therefore goes to 0.
REQ-026 RAM contents are not reset and are undefined until written. While reset is asserted, writes are blocked even if MW=1.
REQ-027 If reset is asserted mid-count, the count is abandoned. After deassertion the timer stays disabled until software sets enable.

Configuration
REQ-028 With macro DMEM_TIMER_EN defined, the timer (REQ-019..023) is built.
REQ-029 Without DMEM_TIMER_EN:
- 0xFFF2 and 0xFFF3 are treated as unmapped (reads 0x0000, bus_err is set).
- timer_irq is tied to 0.
- No timer registers are synthesized.

Verification
REQ-030 RAM round trip: write 0x1234 to 0x0005 with MW=1 for one edge, then MW=0 -> mem_data_in = 0x1234 at address 0x0005; address 0x0006 is unaffected.
REQ-031 GPIO: write 0xA5A5 to 0xFFF0 -> gpio_out = 0xA5A5 after the edge. Drive gpio_in = 0x00FF -> reading 0xFFF1 returns 0x00FF from the 2nd edge after the change, and the old value before that.
REQ-032 Timer wrap (DMEM_TIMER_EN): write 0xFFFE to 0xFFF2, then 0x0005 to 0xFFF3 -> the counter reads 0xFFFF, then 0x0000. The flag sets and timer_irq=1. Writing 0x0002 to 0xFFF3 then clears timer_irq.
REQ-033 Simultaneous events: on the wrap cycle, write 0x0002 to TIMER_CTRL -> the flag remains 1. On an enabled cycle, write 0x0100 to TIMER_CNT -> it reads 0x0100, not 0x0101, on the next cycle.
REQ-034 Unmapped access: read 0x8000 -> mem_data_in = 0x0000 and bus_err=1 after the edge. bus_err stays 1 through later mapped accesses; assert reset -> 0 with no clock edge.
REQ-035 Reset mid-operation: with the timer running and gpio_out = 0x0F0F, pulse reset between clock edges -> all registered outputs are 0 immediately. A write with MW=1 held during reset does not alter the RAM.

Source files
------------

// File: rtl/dmem_top.sv
// dmem_top: data-memory subsystem for the single-cycle datapath.
// It holds a word RAM, a GPIO output register, a synchronized GPIO input,
// and an optional free-running timer with a wrap interrupt.
// Reads are combinational. Writes take effect on the rising edge of clk.
// Optional feature macro: DMEM_TIMER_EN builds the timer at 0xFFF2/0xFFF3.
// Without it, those two addresses are unmapped and timer_irq is tied low.
module dmem_top #(
  parameter int BUS_WIDTH = 16,
  parameter int RAM_AW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MW,
  input  logic [BUS_WIDTH-1:0] dp_address_out,
  input  logic [BUS_WIDTH-1:0] dp_data_out,
  input  logic [BUS_WIDTH-1:0] gpio_in,
  output logic [BUS_WIDTH-1:0] mem_data_in,
  output logic [BUS_WIDTH-1:0] gpio_out,
  output logic                 timer_irq,
  output logic                 bus_err
);

  localparam logic [BUS_WIDTH-1:0] ADDR_GPO  = 16'hFFF0;
  localparam logic [BUS_WIDTH-1:0] ADDR_GPI  = 16'hFFF1;
  localparam logic [BUS_WIDTH-1:0] ADDR_CNT  = 16'hFFF2;
  localparam logic [BUS_WIDTH-1:0] ADDR_CTRL = 16'hFFF3;

  // Storage and registers
  logic [BUS_WIDTH-1:0] r_ram [0:(2**RAM_AW)-1];
  logic [BUS_WIDTH-1:0] r_gpio_out;
  logic [BUS_WIDTH-1:0] r_gpi_meta;
  logic [BUS_WIDTH-1:0] r_gpi_sync;
  logic                 r_bus_err;

  // Decode and datapath wires
  logic                 w_sel_ram;
  logic                 w_sel_gpo;
  logic                 w_sel_gpi;
  logic                 w_sel_cnt;
  logic                 w_sel_ctrl;
  logic                 w_unmapped;
  logic                 w_we_ram;
  logic                 w_we_gpo;
  logic [BUS_WIDTH-1:0] w_ram_rdata;
  logic [BUS_WIDTH-1:0] w_cnt_rdata;
  logic [BUS_WIDTH-1:0] w_ctrl_rdata;
  logic [BUS_WIDTH-1:0] w_rdata;

  // RAM occupies the bottom 2^RAM_AW words. All upper address bits must be zero.
  assign w_sel_ram  = (dp_address_out[BUS_WIDTH-1:RAM_AW] == {(BUS_WIDTH-RAM_AW){1'b0}});
  assign w_sel_gpo  = (dp_address_out == ADDR_GPO);
  assign w_sel_gpi  = (dp_address_out == ADDR_GPI);
  // GPIO_IN is a mapped address, so a write to it is dropped without raising bus_err.
  assign w_unmapped = ~(w_sel_ram | w_sel_gpo | w_sel_gpi | w_sel_cnt | w_sel_ctrl);
  assign w_we_ram   = MW & w_sel_ram;
  assign w_we_gpo   = MW & w_sel_gpo;
  assign w_ram_rdata = r_ram[dp_address_out[RAM_AW-1:0]];

`ifdef DMEM_TIMER_EN
  logic [BUS_WIDTH-1:0] r_tmr_cnt;
  logic                 r_tmr_en;
  logic                 r_tmr_wrap;
  logic                 r_tmr_irqen;
  logic                 w_we_cnt;
  logic                 w_we_ctrl;
  logic                 w_wrap_evt;

  assign w_sel_cnt  = (dp_address_out == ADDR_CNT);
  assign w_sel_ctrl = (dp_address_out == ADDR_CTRL);
  assign w_we_cnt   = MW & w_sel_cnt;
  assign w_we_ctrl  = MW & w_sel_ctrl;
  // A software load of the counter suppresses the wrap in that same cycle.
  assign w_wrap_evt = r_tmr_en & ~w_we_cnt & (r_tmr_cnt == 16'hFFFF);

  // Counter: a software load has priority over the increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmr_cnt <= 16'h0000;
    end else if (w_we_cnt) begin
      r_tmr_cnt <= dp_data_out;
    end else if (r_tmr_en) begin
      r_tmr_cnt <= r_tmr_cnt + 16'h0001;
    end
  end

  // Control bits: enable and irq-enable are plain R/W.
  // The wrap flag is write-1-to-clear, and a wrap in the same cycle wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmr_en    <= 1'b0;
      r_tmr_irqen <= 1'b0;
      r_tmr_wrap  <= 1'b0;
    end else begin
      if (w_we_ctrl) begin
        r_tmr_en    <= dp_data_out[0];
        r_tmr_irqen <= dp_data_out[2];
      end
      if (w_wrap_evt) begin
        r_tmr_wrap <= 1'b1;
      end else if (w_we_ctrl && dp_data_out[1]) begin
        r_tmr_wrap <= 1'b0;
      end
    end
  end

  assign w_cnt_rdata  = r_tmr_cnt;
  assign w_ctrl_rdata = {13'h0000, r_tmr_irqen, r_tmr_wrap, r_tmr_en};
  assign timer_irq    = r_tmr_wrap & r_tmr_irqen;
`else
  assign w_sel_cnt    = 1'b0;
  assign w_sel_ctrl   = 1'b0;
  assign w_cnt_rdata  = 16'h0000;
  assign w_ctrl_rdata = 16'h0000;
  assign timer_irq    = 1'b0;
`endif

  // RAM write port. Contents are not reset, and writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && w_we_ram) begin
      r_ram[dp_address_out[RAM_AW-1:0]] <= dp_data_out;
    end
  end

  // GPIO output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gpio_out <= 16'h0000;
    end else if (w_we_gpo) begin
      r_gpio_out <= dp_data_out;
    end
  end

  // Two-flop synchronizer for the asynchronous input pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gpi_meta <= 16'h0000;
      r_gpi_sync <= 16'h0000;
    end else begin
      r_gpi_meta <= gpio_in;
      r_gpi_sync <= r_gpi_meta;
    end
  end

  // Sticky bus error: any unmapped address present at an edge sets it, whether read or write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_err <= 1'b0;
    end else if (w_unmapped) begin
      r_bus_err <= 1'b1;
    end
  end

  // Zero-latency read mux. Unmapped addresses return zero.
  always_comb begin
    w_rdata = 16'h0000;
    if (w_sel_ram) begin
      w_rdata = w_ram_rdata;
    end else if (w_sel_gpo) begin
      w_rdata = r_gpio_out;
    end else if (w_sel_gpi) begin
      w_rdata = r_gpi_sync;
    end else if (w_sel_cnt) begin
      w_rdata = w_cnt_rdata;
    end else if (w_sel_ctrl) begin
      w_rdata = w_ctrl_rdata;
    end else begin
      w_rdata = 16'h0000;
    end
  end

  assign mem_data_in = w_rdata;
  assign gpio_out    = r_gpio_out;
  assign bus_err     = r_bus_err;

endmodule
